// File: rtl/bringup_pkg.sv
// Shared types and constants for the U500 board bring-up sequencer.
// State encodings are visible on the state port, so their values are fixed.
package bringup_pkg;

  typedef enum logic [2:0] {
    S_HOLD       = 3'd0,
    S_WAIT_LOCK  = 3'd1,
    S_WAIT_CALIB = 3'd2,
    S_WAIT_LINK  = 3'd3,
    S_SETTLE     = 3'd4,
    S_RUN        = 3'd5,
    S_FAIL       = 3'd6
  } state_t;

  localparam logic [1:0] FAIL_NONE          = 2'd0;
  localparam logic [1:0] FAIL_CALIB_TIMEOUT = 2'd1;
  localparam logic [1:0] FAIL_LINK_TIMEOUT  = 2'd2;
  localparam logic [1:0] FAIL_CALIB_LOST    = 2'd3;

  localparam int LED_CALIB     = 0;
  localparam int LED_HEARTBEAT = 1;
  localparam int LED_LINK      = 2;
  localparam int LED_FAIL      = 3;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/bringup_sync.sv
// Flop-chain synchronizer for one asynchronous level input into the core clock.
module bringup_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] chain;

  // NOTE: non-blocking so each stage captures its neighbour's previous value.
  always_ff @(posedge clock) begin
    if (reset) chain <= '0;
    else       chain <= {chain[SYNC_STAGES-2:0], d};
  end

  assign q = chain[SYNC_STAGES-1];

endmodule

// File: rtl/bringup_sequencer.sv
// Reset sequencing for MMCM, DDR4, PCIe bridge and core complex, with
// calibration/link supervision and a four-LED status display.
module bringup_sequencer
  import bringup_pkg::*;
#(
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned HOLD_CYCLES   = 1024,
  parameter int unsigned CALIB_TIMEOUT = 1 << 24,
  parameter int unsigned LINK_TIMEOUT  = 1 << 24,
  parameter int unsigned SETTLE_CYCLES = 64,
  parameter bit          PCIE_REQUIRED = 1'b1,
  parameter int unsigned HB_BITS       = 24
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       restart_req,
  input  logic       mmcm_locked,
  input  logic       ddr_calib_done,
  input  logic       pcie_link_up,
  output logic       ddr_reset,
  output logic       pcie_reset,
  output logic       core_reset,
  output logic [2:0] state,
  output logic [1:0] fail_code,
  output logic [3:0] led
);

  localparam int unsigned TIMER_W = $clog2(max_u(max_u(HOLD_CYCLES, CALIB_TIMEOUT),
                                                 max_u(LINK_TIMEOUT, SETTLE_CYCLES))) + 1;
  localparam logic [TIMER_W-1:0] TIMER_MAX   = '1;
  localparam logic [TIMER_W-1:0] HOLD_LAST   = TIMER_W'(HOLD_CYCLES - 1);
  localparam logic [TIMER_W-1:0] SETTLE_LAST = TIMER_W'(SETTLE_CYCLES - 1);
  localparam logic [TIMER_W-1:0] CALIB_LIMIT = TIMER_W'(CALIB_TIMEOUT);
  localparam logic [TIMER_W-1:0] LINK_LIMIT  = TIMER_W'(LINK_TIMEOUT);

  logic restart_s, locked_s, calib_s, link_s;
  logic restart_q, restart_rise, enter;
  state_t state_q, state_d;
  logic [1:0] fail_q, fail_d;
  logic [TIMER_W-1:0] timer_q;
  logic [HB_BITS-1:0] hb_cnt;
  logic hb_q;

  bringup_sync #(.SYNC_STAGES(SYNC_STAGES)) sync_restart (.clock(clock), .reset(reset), .d(restart_req),    .q(restart_s));
  bringup_sync #(.SYNC_STAGES(SYNC_STAGES)) sync_locked  (.clock(clock), .reset(reset), .d(mmcm_locked),    .q(locked_s));
  bringup_sync #(.SYNC_STAGES(SYNC_STAGES)) sync_calib   (.clock(clock), .reset(reset), .d(ddr_calib_done), .q(calib_s));
  bringup_sync #(.SYNC_STAGES(SYNC_STAGES)) sync_link    (.clock(clock), .reset(reset), .d(pcie_link_up),   .q(link_s));

  assign restart_rise = restart_s & ~restart_q;

  // NOTE: defaults first, so no branch leaves state_d or fail_d unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    fail_d  = fail_q;
    if (restart_rise) begin
      state_d = S_HOLD;
    end else if (!locked_s && state_q != S_HOLD && state_q != S_WAIT_LOCK) begin
      state_d = S_HOLD;
    end else begin
      case (state_q)
        S_HOLD:      if (timer_q == HOLD_LAST) state_d = S_WAIT_LOCK;
        S_WAIT_LOCK: if (locked_s) state_d = S_WAIT_CALIB;
        S_WAIT_CALIB:
          if (calib_s) begin
            state_d = PCIE_REQUIRED ? S_WAIT_LINK : S_SETTLE;
          end else if (timer_q == CALIB_LIMIT) begin
            state_d = S_FAIL;
            fail_d  = FAIL_CALIB_TIMEOUT;
          end
        S_WAIT_LINK:
          if (link_s) begin
            state_d = S_SETTLE;
          end else if (timer_q == LINK_LIMIT) begin
            state_d = S_FAIL;
            fail_d  = FAIL_LINK_TIMEOUT;
          end
        S_SETTLE:    if (timer_q == SETTLE_LAST) state_d = S_RUN;
        S_RUN:
          if (!calib_s) begin
            state_d = S_FAIL;
            fail_d  = FAIL_CALIB_LOST;
          end
        S_FAIL:      state_d = S_FAIL;
        default:     state_d = S_HOLD;
      endcase
    end
    // A restart while already in HOLD still counts as a fresh entry.
    enter = restart_rise || (state_d != state_q);
    if (enter && state_d == S_HOLD) fail_d = FAIL_NONE;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= S_HOLD;
      fail_q    <= FAIL_NONE;
      timer_q   <= '0;
      restart_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      fail_q    <= fail_d;
      restart_q <= restart_s;
      if (enter)                    timer_q <= '0;
      else if (timer_q != TIMER_MAX) timer_q <= timer_q + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset || state_q != S_RUN) begin
      hb_cnt <= '0;
      hb_q   <= 1'b0;
    end else begin
      hb_cnt <= hb_cnt + 1'b1;
      if (&hb_cnt) hb_q <= ~hb_q;
    end
  end

  // Outputs are a registered decode of the state register, one cycle behind it.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= S_HOLD;
      ddr_reset  <= 1'b1;
      pcie_reset <= 1'b1;
      core_reset <= 1'b1;
      fail_code  <= FAIL_NONE;
      led        <= '0;
    end else begin
      state     <= state_q;
      fail_code <= fail_q;
      case (state_q)
        S_WAIT_CALIB:         {ddr_reset, pcie_reset, core_reset} <= 3'b011;
        S_WAIT_LINK, S_SETTLE: {ddr_reset, pcie_reset, core_reset} <= 3'b001;
        S_RUN:                {ddr_reset, pcie_reset, core_reset} <= 3'b000;
        default:              {ddr_reset, pcie_reset, core_reset} <= 3'b111;
      endcase
      led[LED_CALIB]     <= calib_s;
      led[LED_HEARTBEAT] <= hb_q;
      led[LED_LINK]      <= link_s;
      led[LED_FAIL]      <= (state_q == S_FAIL);
    end
  end

endmodule

// File: tb/tb_bringup_sequencer.sv
// Scoreboard bench: scenario tasks predict state-change events from the
// sequencing rules; monitors compare each observed change against them.
module tb_bringup_sequencer;

  localparam int H  = 16;
  localparam int CT = 100;
  localparam int LT = 100;
  localparam int ST = 8;
  localparam int SS = 2;
  localparam int HB = 3;
  localparam int L  = SS + 2;  // input drive -> visible state change

  typedef struct {
    int st;
    int t;
    int fc;
  } ev_t;

  logic clock = 1'b0;
  logic reset, restart_req, mmcm_locked, ddr_calib_done, pcie_link_up;
  logic ddr_reset, pcie_reset, core_reset;
  logic [2:0] state;
  logic [1:0] fail_code;
  logic [3:0] led;

  logic np_reset, np_restart, np_lock, np_calib, np_link;
  logic np_ddr_reset, np_pcie_reset, np_core_reset;
  logic [2:0] np_state;
  logic [1:0] np_fail_code;
  logic [3:0] np_led;

  int cyc = 0;
  int n_vec = 0;
  int n_err = 0;
  int model_state = 0;
  ev_t exp_q[$];
  ev_t np_q[$];
  ev_t mon_e, np_e;
  bit mon_en = 1'b0;
  bit np_en = 1'b0;
  logic [2:0] last_st, np_last;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  bringup_sequencer #(
    .SYNC_STAGES(SS), .HOLD_CYCLES(H), .CALIB_TIMEOUT(CT), .LINK_TIMEOUT(LT),
    .SETTLE_CYCLES(ST), .PCIE_REQUIRED(1'b1), .HB_BITS(HB)
  ) dut (
    .clock(clock), .reset(reset), .restart_req(restart_req), .mmcm_locked(mmcm_locked),
    .ddr_calib_done(ddr_calib_done), .pcie_link_up(pcie_link_up),
    .ddr_reset(ddr_reset), .pcie_reset(pcie_reset), .core_reset(core_reset),
    .state(state), .fail_code(fail_code), .led(led)
  );

  bringup_sequencer #(
    .SYNC_STAGES(SS), .HOLD_CYCLES(H), .CALIB_TIMEOUT(CT), .LINK_TIMEOUT(LT),
    .SETTLE_CYCLES(ST), .PCIE_REQUIRED(1'b0), .HB_BITS(HB)
  ) dut_np (
    .clock(clock), .reset(np_reset), .restart_req(np_restart), .mmcm_locked(np_lock),
    .ddr_calib_done(np_calib), .pcie_link_up(np_link),
    .ddr_reset(np_ddr_reset), .pcie_reset(np_pcie_reset), .core_reset(np_core_reset),
    .state(np_state), .fail_code(np_fail_code), .led(np_led)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Expected {ddr_reset, pcie_reset, core_reset} for each state.
  function automatic logic [2:0] exp_rst(input int st);
    case (st)
      2:       return 3'b011;
      3, 4:    return 3'b001;
      5:       return 3'b000;
      default: return 3'b111;
    endcase
  endfunction

  function automatic ev_t mk(input int st, input int t, input int fc);
    ev_t e;
    e.st = st;
    e.t  = t;
    e.fc = fc;
    return e;
  endfunction

  task automatic push(input int st, input int t, input int fc);
    exp_q.push_back(mk(st, t, fc));
    model_state = st;
  endtask

  task automatic wait_until(input int n);
    while (cyc < n) @(negedge clock);
  endtask

  task automatic drain(input string name);
    int k = 0;
    while (exp_q.size() != 0 && k < 400) begin
      @(negedge clock);
      k++;
    end
    check({"drain_", name}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  // HOLD -> WAIT_LOCK -> WAIT_CALIB -> WAIT_LINK -> SETTLE -> RUN with all inputs already good.
  task automatic push_resequence(input int h);
    push(0, h, 0);
    push(1, h + H, 0);
    push(2, h + H + 1, 0);
    push(3, h + H + 2, 0);
    push(4, h + H + 3, 0);
    push(5, h + H + 3 + ST, 0);
  endtask

  task automatic start_seq(output int r);
    @(negedge clock);
    reset = 1'b1;
    mmcm_locked = 1'b1;
    ddr_calib_done = 1'b0;
    pcie_link_up = 1'b0;
    restart_req = 1'b0;
    if (model_state != 0) push(0, cyc + 1, 0);
    repeat (3) @(negedge clock);
    reset = 1'b0;
    r = cyc;
    push(1, r + H + 1, 0);
    push(2, r + H + 2, 0);
  endtask

  // Offsets are cycles after reset release; negative means the input never rises.
  task automatic run_seq(input int cal_off, input int link_off);
    int r, ec, rc, el, rl;
    start_seq(r);
    ec = r + H + 2;
    rc = r + cal_off + L;
    if (rc < ec + 1) rc = ec + 1;
    if (cal_off < 0 || rc > ec + CT + 1) begin
      push(6, ec + CT + 1, 1);
    end else begin
      push(3, rc, 0);
      el = rc;
      rl = r + link_off + L;
      if (rl < el + 1) rl = el + 1;
      if (link_off < 0 || rl > el + LT + 1) begin
        push(6, el + LT + 1, 2);
      end else begin
        push(4, rl, 0);
        push(5, rl + ST, 0);
      end
    end
    if (cal_off >= 0) begin
      wait_until(r + cal_off);
      ddr_calib_done = 1'b1;
    end
    if (link_off >= 0) begin
      wait_until(r + link_off);
      pcie_link_up = 1'b1;
    end
    drain("seq");
  endtask

  always @(negedge clock) begin
    if (mon_en && state !== last_st) begin
      if (exp_q.size() == 0) begin
        check("unexpected_state_change", state, last_st);
      end else begin
        mon_e = exp_q.pop_front();
        check("state", state, mon_e.st);
        check("change_cycle", cyc, mon_e.t);
        check("fail_code", fail_code, mon_e.fc);
        check("resets", {ddr_reset, pcie_reset, core_reset}, exp_rst(mon_e.st));
        check("fail_led", led[3], (mon_e.st == 6) ? 1 : 0);
      end
      last_st = state;
    end
  end

  always @(negedge clock) begin
    if (np_en && np_state !== np_last) begin
      if (np_q.size() == 0) begin
        check("np_unexpected_state_change", np_state, np_last);
      end else begin
        np_e = np_q.pop_front();
        check("np_state", np_state, np_e.st);
        check("np_change_cycle", cyc, np_e.t);
        check("np_fail_code", np_fail_code, np_e.fc);
        check("np_resets", {np_ddr_reset, np_pcie_reset, np_core_reset}, exp_rst(np_e.st));
      end
      np_last = np_state;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int r, n, c, ec, tog, k;
    logic prev;
    reset = 1'b1; restart_req = 1'b0; mmcm_locked = 1'b1; ddr_calib_done = 1'b0; pcie_link_up = 1'b0;
    np_reset = 1'b1; np_restart = 1'b0; np_lock = 1'b1; np_calib = 1'b0; np_link = 1'b0;
    repeat (4) @(negedge clock);
    check("reset_state", state, 0);
    check("reset_resets", {ddr_reset, pcie_reset, core_reset}, 3'b111);
    check("reset_fail_code", fail_code, 0);
    check("reset_led", led, 0);
    last_st = state;
    mon_en = 1'b1;

    // Link never required: WAIT_CALIB goes straight to SETTLE.
    np_last = np_state;
    np_en = 1'b1;
    np_reset = 1'b0;
    r = cyc;
    c = $urandom_range(22, 60);
    np_q.push_back(mk(1, r + H + 1, 0));
    np_q.push_back(mk(2, r + H + 2, 0));
    np_q.push_back(mk(4, r + c + L, 0));
    np_q.push_back(mk(5, r + c + L + ST, 0));
    wait_until(r + c);
    np_calib = 1'b1;
    k = 0;
    while (np_q.size() != 0 && k < 400) begin
      @(negedge clock);
      k++;
    end
    check("np_drain", np_q.size(), 0);
    repeat (5) @(negedge clock);
    check("np_run_state", np_state, 5);
    check("np_run_fail_code", np_fail_code, 0);
    check("np_led_link", np_led[2], 0);

    // Nominal: calib at 40, link at 70, then status LEDs and heartbeat in RUN.
    run_seq(40, 70);
    check("run_led_calib", led[0], 1);
    check("run_led_link", led[2], 1);
    prev = led[1];
    tog = 0;
    repeat (32) begin
      @(negedge clock);
      if (led[1] !== prev) tog++;
      prev = led[1];
    end
    check("heartbeat_toggles", tog, 32 >> HB);

    for (int i = 0; i < 2; i++) begin
      c = $urandom_range(22, 60);
      run_seq(c, c + $urandom_range(1, 50));
    end

    // Lock dropped for 5 cycles in RUN.
    @(negedge clock);
    n = cyc;
    mmcm_locked = 1'b0;
    push_resequence(n + L);
    repeat (5) @(negedge clock);
    mmcm_locked = 1'b1;
    drain("lock_drop");

    // Calibration lost in RUN.
    @(negedge clock);
    n = cyc;
    ddr_calib_done = 1'b0;
    push(6, n + L, 3);
    drain("calib_lost");

    // Calibration never completes.
    run_seq(-1, -1);
    check("calib_fail_led_calib", led[0], 0);

    // Restart pulse from FAIL, then a held restart level.
    repeat ($urandom_range(3, 10)) @(negedge clock);
    n = cyc;
    restart_req = 1'b1;
    push(0, n + L, 0);
    push(1, n + L + H, 0);
    push(2, n + L + H + 1, 0);
    push(6, n + L + H + 2 + CT, 1);
    repeat (3) @(negedge clock);
    restart_req = 1'b0;
    drain("restart_pulse");
    @(negedge clock);
    n = cyc;
    restart_req = 1'b1;
    push(0, n + L, 0);
    push(1, n + L + H, 0);
    push(2, n + L + H + 1, 0);
    push(6, n + L + H + 2 + CT, 1);
    drain("restart_held");
    repeat (40) @(negedge clock);
    restart_req = 1'b0;
    repeat (10) @(negedge clock);
    check("restart_held_no_retrigger", state, 6);

    // Link never comes up.
    run_seq($urandom_range(22, 40), -1);

    // Calibration completing on the timeout cycle wins; one cycle later fails.
    run_seq(H + CT - 1, H + CT + 14);
    run_seq(H + CT, -1);

    // Calib drop and restart edge in the same cycle: restart wins.
    run_seq($urandom_range(22, 40), 80);
    @(negedge clock);
    n = cyc;
    ddr_calib_done = 1'b0;
    restart_req = 1'b1;
    push(0, n + L, 0);
    push(1, n + L + H, 0);
    push(2, n + L + H + 1, 0);
    drain("calib_drop_vs_restart");

    // Lock loss on the same cycle as the calibration timeout: lock loss wins.
    start_seq(r);
    ec = r + H + 2;
    wait_until(ec + CT + 1 - L);
    n = cyc;
    mmcm_locked = 1'b0;
    push(0, n + L, 0);
    push(1, n + L + H, 0);
    push(2, n + L + H + 1, 0);
    repeat (5) @(negedge clock);
    mmcm_locked = 1'b1;
    drain("lock_loss_vs_timeout");

    @(negedge clock);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
